// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive sequencer: sync+deglitch pins, frame 11-bit words, check parity/stop, buffer bytes in a FIFO.
// Pin edge to fall strobe is 2+FILTER_LEN cycles; the byte is visible 1 cycle after the stop fall. There is no backpressure: a full FIFO drops bytes (ovf_o).
module ps2_rx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  input  logic                          rd_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          par_err_o,
  output logic                          frm_err_o,
  output logic                          ovf_o,
  input  logic                          irq_en_i,
  output logic                          irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Index 0 is the PS/2 clock, index 1 is the PS/2 data line.
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_fall;

  state_t        r_state;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bit_cnt;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_irq;

  logic w_dat_f;
  logic w_full;
  logic w_pop;
  logic w_good;
  logic w_push;
  logic w_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1   <= 2'b11;
      r_s2   <= 2'b11;
      r_filt <= 2'b11;
      r_fall <= 1'b0;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_s1 <= {ps2_dat_i, ps2_clk_i};
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
      // Strobe lands in the same cycle the filtered clock first reads 0.
      r_fall <= r_filt[0] & ~r_s2[0] & (r_fcnt[0] == FW'(FILTER_LEN - 1));
    end
  end

  assign w_dat_f = r_filt[1];
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = rd_i & (r_count != '0);
  assign w_good  = en_i & r_fall & (r_state == S_STOP) & w_dat_f & (^{r_shreg, r_par});
  assign w_push  = w_good & (~w_full | w_pop);
  assign w_ovf   = w_good & w_full & ~w_pop & ~clr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      par_err_o <= 1'b0;
      frm_err_o <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      par_err_o <= 1'b0;
      frm_err_o <= 1'b0;
      ovf_o     <= w_ovf;
      if (!en_i) begin
        r_state  <= S_IDLE;
        r_to_cnt <= '0;
      end else if (r_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat_f) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shreg   <= {w_dat_f, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_dat_f;
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (!w_dat_f)                 frm_err_o <= 1'b1;
            else if (!(^{r_shreg, r_par})) par_err_o <= 1'b1;
          end
        endcase
      end else if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        r_state   <= S_IDLE;
        r_to_cnt  <= '0;
        frm_err_o <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shreg;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= irq_en_i & valid_o;
      if (clr_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign valid_o = (r_count != '0);
  assign data_o  = valid_o ? r_mem[r_rd_ptr] : 8'h00;
  assign count_o = r_count;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: bit-banged PS/2 frames with hand-computed expected bytes and pulse counts.
module tb_ps2_rx_ctrl;

  localparam int HALF = 12;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic       clr_i = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_dat_i = 1'b1;
  logic       rd_i = 1'b0;
  logic       irq_en_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [3:0] count_o;
  logic       par_err_o;
  logic       frm_err_o;
  logic       ovf_o;
  logic       irq_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;
  int b_par, b_frm, b_ovf;

  ps2_rx_ctrl #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYC(20000)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i), .rd_i(rd_i),
    .data_o(data_o), .valid_o(valid_o), .count_o(count_o),
    .par_err_o(par_err_o), .frm_err_o(frm_err_o), .ovf_o(ovf_o),
    .irq_en_i(irq_en_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Cycles-high counters: a correct 1-cycle pulse adds exactly 1 per event.
  always @(negedge clk) begin
    if (par_err_o) n_par <= n_par + 1;
    if (frm_err_o) n_frm <= n_frm + 1;
    if (ovf_o)     n_ovf <= n_ovf + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_par = n_par;
    b_frm = n_frm;
    b_ovf = n_ovf;
  endtask

  task automatic send_bit(input logic b, input bit glitch, input bit rd_at_push);
    ps2_dat_i = b;
    if (glitch) begin
      wait_cyc(4);
      ps2_clk_i = 1'b0;
      wait_cyc(3);
      ps2_clk_i = 1'b1;
      wait_cyc(HALF - 7);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk_i = 1'b0;
    if (rd_at_push) begin
      wait_cyc(6);
      rd_i = 1'b1;
      wait_cyc(1);
      rd_i = 1'b0;
      wait_cyc(HALF - 7);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int glitch_bit, input bit rd_at_push);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch_bit == i, 1'b0);
    send_bit(~(^d) ^ bad_par, 1'b0, 1'b0);
    send_bit(~bad_stop, 1'b0, rd_at_push);
    ps2_dat_i = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i], 1'b0, 1'b0);
  endtask

  task automatic pop();
    rd_i = 1'b1;
    wait_cyc(1);
    rd_i = 1'b0;
  endtask

  initial begin
    wait_cyc(5);
    rst_i = 1'b0;
    wait_cyc(1);
    check("rst count", count_o, 0);
    check("rst valid", valid_o, 0);
    check("rst data", data_o, 0);
    check("rst irq", irq_o, 0);
    check("rst errs", {par_err_o, frm_err_o, ovf_o}, 0);

    // Basic frame with interrupt enabled
    irq_en_i = 1'b1;
    snap();
    send_frame(8'h1C, 0, 0, -1, 0);
    check("t1 count", count_o, 1);
    check("t1 data", data_o, 8'h1C);
    check("t1 irq", irq_o, 1);
    check("t1 no err", (n_par - b_par) + (n_frm - b_frm) + (n_ovf - b_ovf), 0);
    pop();
    check("t1 pop count", count_o, 0);
    check("t1 empty data", data_o, 0);
    wait_cyc(1);
    check("t1 irq clr", irq_o, 0);
    pop();
    check("t1 pop empty", count_o, 0);

    // Parity error, then bad stop bit
    snap();
    send_frame(8'h1C, 1, 0, -1, 0);
    check("t2 par pulse", n_par - b_par, 1);
    check("t2 par no frm", n_frm - b_frm, 0);
    check("t2 par count", count_o, 0);
    snap();
    send_frame(8'h1C, 0, 1, -1, 0);
    check("t2 frm pulse", n_frm - b_frm, 1);
    check("t2 frm no par", n_par - b_par, 0);
    check("t2 frm count", count_o, 0);

    // Timeout after 5 data bits
    snap();
    send_partial(8'h15, 5);
    wait_cyc(19900);
    check("t3 early frm", n_frm - b_frm, 0);
    wait_cyc(200);
    check("t3 timeout frm", n_frm - b_frm, 1);
    check("t3 no par", n_par - b_par, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    check("t3 next count", count_o, 1);
    check("t3 next data", data_o, 8'hF0);
    pop();

    // Overflow on the ninth frame
    snap();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, -1, 0);
    check("t4 ovf pulse", n_ovf - b_ovf, 1);
    check("t4 full count", count_o, 8);
    for (int i = 1; i <= 8; i++) begin
      check("t4 pop data", data_o, i);
      pop();
    end
    check("t4 drained", count_o, 0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) send_frame(8'(8'h10 + i), 0, 0, -1, 0);
    snap();
    send_frame(8'h18, 0, 0, -1, 1);
    check("t4b no ovf", n_ovf - b_ovf, 0);
    check("t4b count", count_o, 8);
    for (int i = 1; i <= 8; i++) begin
      check("t4b pop data", data_o, 8'h10 + i);
      pop();
    end

    // Short clock glitch inside a frame
    snap();
    send_frame(8'h5A, 0, 0, 3, 0);
    check("t5 count", count_o, 1);
    check("t5 data", data_o, 8'h5A);
    check("t5 no err", (n_par - b_par) + (n_frm - b_frm), 0);
    pop();

    // Reset mid-frame
    snap();
    send_partial(8'h0F, 4);
    rst_i = 1'b1;
    wait_cyc(2);
    rst_i = 1'b0;
    wait_cyc(30);
    send_frame(8'hAA, 0, 0, -1, 0);
    check("t6 rst no err", (n_par - b_par) + (n_frm - b_frm), 0);
    check("t6 rst count", count_o, 1);
    check("t6 rst data", data_o, 8'hAA);
    pop();

    // Enable dropped mid-frame; FIFO contents survive
    send_frame(8'h33, 0, 0, -1, 0);
    snap();
    send_partial(8'h0F, 4);
    en_i = 1'b0;
    wait_cyc(2);
    en_i = 1'b1;
    wait_cyc(30);
    check("t6 en kept count", count_o, 1);
    send_frame(8'hAA, 0, 0, -1, 0);
    check("t6 en no err", (n_par - b_par) + (n_frm - b_frm), 0);
    check("t6 en count", count_o, 2);
    check("t6 en head", data_o, 8'h33);
    pop();
    check("t6 en second", data_o, 8'hAA);

    // Flush
    clr_i = 1'b1;
    wait_cyc(1);
    clr_i = 1'b0;
    check("clr count", count_o, 0);
    check("clr valid", valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
